bus_interconnect: RTL and testbench

BUS_INTERCONNECT -- requirements
Module: bus_interconnect

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_timer.sv | 34 +++
 rtl/bus_interconnect.sv | 193 +++++++++++++++++++
 tb/tb_bus_interconnect.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared FSM state type and default constants for bus_interconnect.
// Revision : 1.0
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT   = 32'hDEAD_BEEF;
    localparam int          REGION_LSB_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : bus_timer
// Brief    : ACCESS-phase watchdog; expired is high in the TIMEOUT-th enabled cycle.
// Revision : 1.0
// ============================================================================
module bus_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/bus_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : bus_interconnect
// Brief    : Single-master to N-slave address-decoded bridge with timeout.
// Revision : 1.0
// ============================================================================
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int                N_SLAVES   = 4,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                REGION_LSB = REGION_LSB_DEFAULT,
    parameter int                TIMEOUT    = 16,
    parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic [DATA_W-1:0]          m_wdata,
    input  logic                       m_read,
    input  logic                       m_write,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_ready,
    output logic                       m_err,
    output logic [N_SLAVES-1:0]        s_sel,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    output logic                       s_read,
    output logic                       s_write,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]        s_ready,
    output logic                       busy,
    output logic [7:0]                 err_count
);

    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int RGN_W = ADDR_W - REGION_LSB;

    bus_state_e          state_q, state_d;
    logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
    logic                m_ready_q, m_ready_d;
    logic                m_err_q, m_err_d;
    logic [N_SLAVES-1:0] s_sel_q, s_sel_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic                s_read_q, s_read_d;
    logic                s_write_q, s_write_d;
    logic [SEL_W-1:0]    region_q, region_d;
    logic                busy_q;
    logic [7:0]          err_count_q, err_count_d;

    logic                timer_clear, timer_en, timer_expired;
    logic [RGN_W-1:0]    req_region;
    logic                req_bad;
    logic [DATA_W-1:0]   slv_rdata;
    logic                slv_ready;

    assign req_region = m_addr[ADDR_W-1:REGION_LSB];
    assign req_bad    = (m_read && m_write) || (32'(req_region) >= 32'(N_SLAVES));

    // Only the latched region's ready/data are visible; other slaves are ignored.
    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (SEL_W'(i) == region_q) begin
                slv_rdata = s_rdata[i*DATA_W +: DATA_W];
                slv_ready = s_ready[i];
            end
        end
    end

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        m_rdata_d   = m_rdata_q;
        m_ready_d   = 1'b0;
        m_err_d     = 1'b0;
        s_sel_d     = s_sel_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_read_d    = s_read_q;
        s_write_d   = s_write_q;
        region_d    = region_q;
        err_count_d = err_count_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
                if (m_read || m_write) begin
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    region_d  = SEL_W'(req_region);
                    if (req_bad) begin
                        state_d   = ST_RESP;
                        m_ready_d = 1'b1;
                        m_err_d   = 1'b1;
                        m_rdata_d = ERR_DATA;
                    end else begin
                        state_d   = ST_ACCESS;
                        s_sel_d   = N_SLAVES'(1) << SEL_W'(req_region);
                        s_read_d  = m_read;
                        s_write_d = m_write;
                    end
                end
            end
            ST_ACCESS: begin
                timer_en = 1'b1;
                // A ready arriving in the final allowed cycle wins over the timeout.
                if (slv_ready) begin
                    state_d   = ST_RESP;
                    m_ready_d = 1'b1;
                    m_rdata_d = s_read_q ? slv_rdata : '0;
                end else if (timer_expired) begin
                    state_d   = ST_RESP;
                    m_ready_d = 1'b1;
                    m_err_d   = 1'b1;
                    m_rdata_d = ERR_DATA;
                end
                if (state_d == ST_RESP) begin
                    s_sel_d   = '0;
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (m_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            m_rdata_q   <= '0;
            m_ready_q   <= 1'b0;
            m_err_q     <= 1'b0;
            s_sel_q     <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_read_q    <= 1'b0;
            s_write_q   <= 1'b0;
            region_q    <= '0;
            busy_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            m_rdata_q   <= m_rdata_d;
            m_ready_q   <= m_ready_d;
            m_err_q     <= m_err_d;
            s_sel_q     <= s_sel_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_read_q    <= s_read_d;
            s_write_q   <= s_write_d;
            region_q    <= region_d;
            busy_q      <= (state_d != ST_IDLE);
            err_count_q <= err_count_d;
        end
    end

    assign m_rdata   = m_rdata_q;
    assign m_ready   = m_ready_q;
    assign m_err     = m_err_q;
    assign s_sel     = s_sel_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_read    = s_read_q;
    assign s_write   = s_write_q;
    assign busy      = busy_q;
    assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_interconnect
// Brief    : Vector table + scoreboard bench for bus_interconnect.
// Revision : 1.0
// ============================================================================
module tb_bus_interconnect;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_wdata = '0;
    logic            m_read = 1'b0;
    logic            m_write = 1'b0;
    logic [DW-1:0]   m_rdata;
    logic            m_ready;
    logic            m_err;
    logic [N-1:0]    s_sel;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_read;
    logic            s_write;
    logic [N*DW-1:0] s_rdata = '0;
    logic [N-1:0]    s_ready = '0;
    logic            busy;
    logic [7:0]      err_count;

    always #5 clk = ~clk;

    bus_interconnect #(
        .N_SLAVES (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_read    (m_read),
        .m_write   (m_write),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .m_err     (m_err),
        .s_sel     (s_sel),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_read    (s_read),
        .s_write   (s_write),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready),
        .busy      (busy),
        .err_count (err_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [31:0] slv_rdata;
        int          wait_c;     // ACCESS cycles before ready; -1 = never
        logic        other_rdy;  // non-target slaves hold ready high
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [7:0]  errcnt;
    } exp_t;

    vec_t vecs [8];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_errcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          slv;
        logic        mapped;
        logic [N-1:0] exp_sel;
        exp_t        e;
        exp_t        got;
        bit          done;
        slv     = int'(v.addr[31:16]);
        mapped  = (slv < N) && !(v.rd && v.wr);
        exp_sel = mapped ? (N'(1) << slv) : '0;
        if (v.exp_err) exp_errcnt = (exp_errcnt == 255) ? 255 : exp_errcnt + 1;
        e = '{v.exp_rdata, v.exp_err, v.exp_lat, 8'(exp_errcnt)};

        @(negedge clk);
        m_addr  = v.addr;
        m_wdata = v.wdata;
        m_read  = v.rd;
        m_write = v.wr;
        for (int i = 0; i < N; i++)
            s_rdata[i*DW +: DW] = (i == slv) ? v.slv_rdata : $urandom();
        s_ready = (mapped && v.other_rdy) ? ~exp_sel : '0;
        sb.push_back(e);

        done = 1'b0;
        for (int c = 2; c <= 40 && !done; c++) begin
            @(negedge clk);
            // Master-side noise while busy must have no effect.
            m_addr  = $urandom();
            m_wdata = $urandom();
            if (mapped && v.wait_c >= 0) s_ready[slv] = (c - 2 == v.wait_c);
            if (m_ready) begin
                done    = 1'b1;
                m_read  = 1'b0;
                m_write = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    got = sb.pop_front();
                    check("latency", 64'(c), 64'(got.lat));
                    check("m_rdata", 64'(m_rdata), 64'(got.rdata));
                    check("m_err", 64'(m_err), 64'(got.err));
                    check("err_count", 64'(err_count), 64'(got.errcnt));
                    check("s_sel_resp", 64'(s_sel), 0);
                    check("busy_resp", 64'(busy), 1);
                end
            end else begin
                check("busy_access", 64'(busy), 1);
                check("s_sel_access", 64'(s_sel), 64'(exp_sel));
                if (mapped) begin
                    check("s_addr_held", 64'(s_addr), 64'(v.addr));
                    check("s_wdata_held", 64'(s_wdata), 64'(v.wdata));
                    check("s_dir_held", {62'b0, s_read, s_write}, {62'b0, v.rd, v.wr});
                end
            end
        end
        if (!done) begin
            check("ready_timeout", 0, 1);
            m_read  = 1'b0;
            m_write = 1'b0;
            if (sb.size() > 0) void'(sb.pop_front());
        end
        s_ready = '0;
        @(negedge clk);
        check("ready_pulse_end", 64'(m_ready), 0);
        check("busy_idle", 64'(busy), 0);
        check("m_rdata_hold", 64'(m_rdata), 64'(e.rdata));
    endtask

    initial begin
        vecs[0] = '{32'h0001_0004, 32'h0,         1, 0, 32'h1234_5678, 0,  0, 32'h1234_5678, 0, 3};
        vecs[1] = '{32'h0002_0000, 32'hA5A5_A5A5, 0, 1, 32'h7777_7777, 3,  0, 32'h0,         0, 6};
        vecs[2] = '{32'h0007_0000, 32'h0,         1, 0, 32'h0,         0,  0, 32'hDEAD_BEEF, 1, 2};
        vecs[3] = '{32'h0000_0000, 32'h0,         1, 0, 32'h1111_1111, -1, 1, 32'hDEAD_BEEF, 1, 18};
        vecs[4] = '{32'h0001_0000, 32'h5,         1, 1, 32'h2222_2222, 0,  0, 32'hDEAD_BEEF, 1, 2};
        vecs[5] = '{32'h0003_00FC, 32'h0,         1, 0, 32'hCAFE_F00D, 1,  1, 32'hCAFE_F00D, 0, 4};
        vecs[6] = '{32'h0000_0010, 32'h0000_0001, 0, 1, 32'h3333_3333, 0,  0, 32'h0,         0, 3};
        vecs[7] = '{32'h0002_0008, 32'h0,         1, 0, 32'h0BAD_F00D, 15, 0, 32'h0BAD_F00D, 0, 18};

        #2 rst = 1'b1;
        #1;
        check("rst_m_ready", 64'(m_ready), 0);
        check("rst_m_err", 64'(m_err), 0);
        check("rst_m_rdata", 64'(m_rdata), 0);
        check("rst_s_sel", 64'(s_sel), 0);
        check("rst_s_strobes", {62'b0, s_read, s_write}, 0);
        check("rst_s_addr", 64'(s_addr), 0);
        check("rst_s_wdata", 64'(s_wdata), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_err_count", 64'(err_count), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        for (int k = 0; k < 260; k++) run_vec(vecs[2]);
        check("err_count_saturated", 64'(err_count), 255);

        // Reset in the middle of an access to slave 1 that never responds.
        @(negedge clk);
        m_addr  = 32'h0001_0000;
        m_read  = 1'b1;
        s_ready = '0;
        @(negedge clk);
        m_read = 1'b0;
        check("abort_s_sel_before", 64'(s_sel), 64'h2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_s_sel", 64'(s_sel), 0);
        check("abort_s_read", 64'(s_read), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_err_count", 64'(err_count), 0);
        exp_errcnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_no_ready", 64'(m_ready), 0);
        end
        run_vec(vecs[0]);
        run_vec(vecs[2]);

        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
